// File: rtl/debounce_inputs.sv
// debounce_inputs: synchronise, debounce and edge-detect raw switch/button inputs.
// Long-press pulses on in_long are built only when DEBOUNCE_LONG_PRESS_EN is defined.
module debounce_inputs #(
  parameter int N_IN         = 5,
  parameter int SYNC_STAGES  = 2,
  parameter int TICK_DIV     = 10000,
  parameter int STABLE_TICKS = 20
`ifdef DEBOUNCE_LONG_PRESS_EN
  ,
  parameter int LONG_TICKS   = 1000
`endif
) (
  input  logic            clk_10mhz,
  input  logic            rst_n,
  input  logic [N_IN-1:0] in_raw,
  output logic [N_IN-1:0] in_db,
  output logic [N_IN-1:0] in_rise,
  output logic [N_IN-1:0] in_fall,
  output logic            sample_tick,
  output logic [N_IN-1:0] in_long
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(STABLE_TICKS + 1);
  localparam logic [PW-1:0] PRE_MAX = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_TICKS - 1);

  logic [N_IN-1:0] sync_q [SYNC_STAGES];
  logic [N_IN-1:0] s;
  logic [PW-1:0]   pre;
  logic [CW-1:0]   cnt [N_IN];

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < SYNC_STAGES; k++) begin
        sync_q[k] <= '0;
      end
    end else begin
      sync_q[0] <= in_raw;
      for (int k = 1; k < SYNC_STAGES; k++) begin
        sync_q[k] <= sync_q[k-1];
      end
    end
  end

  // Tick is registered so it is low in reset even when TICK_DIV is 1.
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      pre         <= '0;
      sample_tick <= 1'b0;
    end else begin
      sample_tick <= (pre == PRE_MAX);
      pre         <= (pre == PRE_MAX) ? '0 : pre + 1'b1;
    end
  end

  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      in_db   <= '0;
      in_rise <= '0;
      in_fall <= '0;
      for (int i = 0; i < N_IN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      in_rise <= '0;
      in_fall <= '0;
      for (int i = 0; i < N_IN; i++) begin
        if (s[i] == in_db[i]) begin
          cnt[i] <= '0;
        end else if (sample_tick) begin
          if (cnt[i] == CNT_MAX) begin
            cnt[i]     <= '0;
            in_db[i]   <= s[i];
            in_rise[i] <= s[i];
            in_fall[i] <= ~s[i];
          end else begin
            cnt[i] <= cnt[i] + 1'b1;
          end
        end
      end
    end
  end

`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int HW = $clog2(LONG_TICKS + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_TICKS);

  logic [HW-1:0] hold [N_IN];

  // Saturating hold count makes the pulse fire once per press.
  always_ff @(posedge clk_10mhz or negedge rst_n) begin
    if (!rst_n) begin
      in_long <= '0;
      for (int i = 0; i < N_IN; i++) begin
        hold[i] <= '0;
      end
    end else begin
      in_long <= '0;
      for (int i = 0; i < N_IN; i++) begin
        if (!in_db[i]) begin
          hold[i] <= '0;
        end else if (sample_tick && hold[i] != HOLD_MAX) begin
          hold[i]    <= hold[i] + 1'b1;
          in_long[i] <= (hold[i] == HOLD_MAX - 1'b1);
        end
      end
    end
  end
`else
  assign in_long = '0;
`endif

endmodule

// File: tb/tb_debounce_inputs.sv
// tb_debounce_inputs: directed and random stimulus for debounce_inputs
// against a tick-counting reference model.
module tb_debounce_inputs;

  localparam int N  = 5;
  localparam int SY = 2;
  localparam int TD = 4;
  localparam int ST = 3;
  localparam int LT = 5;
`ifdef DEBOUNCE_LONG_PRESS_EN
  localparam int EXP_LONG = 1;
`else
  localparam int EXP_LONG = 0;
`endif

  logic         clk;
  logic         rst_n;
  logic [N-1:0] in_raw;
  logic [N-1:0] in_db;
  logic [N-1:0] in_rise;
  logic [N-1:0] in_fall;
  logic         sample_tick;
  logic [N-1:0] in_long;

  int checks;
  int errors;

  debounce_inputs #(
    .N_IN(N),
    .SYNC_STAGES(SY),
    .TICK_DIV(TD),
    .STABLE_TICKS(ST)
`ifdef DEBOUNCE_LONG_PRESS_EN
    ,
    .LONG_TICKS(LT)
`endif
  ) dut (
    .clk_10mhz(clk),
    .rst_n(rst_n),
    .in_raw(in_raw),
    .in_db(in_db),
    .in_rise(in_rise),
    .in_fall(in_fall),
    .sample_tick(sample_tick),
    .in_long(in_long)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Reference model: raw history gives the synchronised view, ticks are
  // every TD-th edge after reset, a level is accepted after ST
  // consecutive disagreeing ticks, a long press after LT held ticks.
  logic [N-1:0] m_db, m_rise, m_fall, m_long;
  logic         m_tick;
  int           m_run [N];
  int           m_hold [N];
  int           m_edges;
  logic [N-1:0] hist [$];

  task automatic model_reset();
    m_db = '0; m_rise = '0; m_fall = '0; m_long = '0;
    m_tick = 1'b0; m_edges = 0;
    hist.delete();
    for (int i = 0; i < N; i++) begin
      m_run[i] = 0;
      m_hold[i] = 0;
    end
  endtask

  task automatic model_edge();
    logic [N-1:0] sv;
    logic [N-1:0] db_old;
    logic tk;
    if (!rst_n) begin
      model_reset();
      return;
    end
    tk = m_tick;
    db_old = m_db;
    sv = (hist.size() >= SY) ? hist[hist.size()-SY] : '0;
    hist.push_back(in_raw);
    if (hist.size() > SY) void'(hist.pop_front());
    m_rise = '0; m_fall = '0; m_long = '0;
    for (int i = 0; i < N; i++) begin
      if (sv[i] == db_old[i]) begin
        m_run[i] = 0;
      end else if (tk) begin
        m_run[i]++;
        if (m_run[i] == ST) begin
          m_run[i] = 0;
          m_db[i] = sv[i];
          m_rise[i] = sv[i];
          m_fall[i] = ~sv[i];
        end
      end
      if (EXP_LONG == 1) begin
        if (!db_old[i]) begin
          m_hold[i] = 0;
        end else if (tk && m_hold[i] < LT) begin
          m_hold[i]++;
          if (m_hold[i] == LT) m_long[i] = 1'b1;
        end
      end
    end
    m_edges++;
    m_tick = (m_edges % TD == 0);
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    logic exp_tick;
    rst_n = 1'b0;
    in_raw = '0;
    model_reset();
    repeat (5) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: got %b expected 0",
                 {in_db, in_rise, in_fall, in_long, sample_tick});
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      cycle();
      exp_tick = (k % TD == 0);
      checks++;
      if (sample_tick !== exp_tick) begin
        errors++;
        $display("FAIL reset_tick edge %0d: got %b expected %b", k, sample_tick, exp_tick);
      end
      checks++;
      if ({in_db, in_rise, in_fall, in_long} !== '0) begin
        errors++;
        $display("FAIL reset_idle: got %b expected 0", {in_db, in_rise, in_fall, in_long});
      end
    end
  endtask

  task automatic test_clean_rise();
    int lat, rises, falls, rise_at;
    lat = 0; rises = 0; falls = 0; rise_at = -1;
    in_raw[0] = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL rise_model cyc %0d: got %b expected %b", k,
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (in_rise[0]) begin rises++; rise_at = k; end
      if (in_fall !== '0) falls++;
      if (lat == 0 && in_db[0]) lat = k;
    end
    checks++;
    if (lat < SY + (ST-1)*TD + 1 || lat > SY + ST*TD) begin
      errors++;
      $display("FAIL rise_latency: got %0d expected 11..14", lat);
    end
    checks++;
    if (rises != 1 || rise_at != lat) begin
      errors++;
      $display("FAIL rise_pulse: got %0d pulses at %0d expected 1 at %0d", rises, rise_at, lat);
    end
    checks++;
    if (falls != 0 || in_db[4:1] !== 4'b0000) begin
      errors++;
      $display("FAIL rise_others: got falls %0d db %b expected 0", falls, in_db[4:1]);
    end
  endtask

  task automatic test_bounce();
    int pulses, lat, rises;
    pulses = 0; lat = 0; rises = 0;
    for (int p = 0; p < 4; p++) begin
      in_raw[1] = (p % 2 == 0);
      repeat (3) begin
        cycle();
        checks++;
        if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
            {m_db, m_rise, m_fall, m_long, m_tick}) begin
          errors++;
          $display("FAIL bounce_model: got %b expected %b",
                   {in_db, in_rise, in_fall, in_long, sample_tick},
                   {m_db, m_rise, m_fall, m_long, m_tick});
        end
        if (in_rise[1] || in_fall[1]) pulses++;
      end
    end
    checks++;
    if (pulses != 0 || in_db[1] !== 1'b0) begin
      errors++;
      $display("FAIL bounce_quiet: got %0d pulses db %b expected 0", pulses, in_db[1]);
    end
    in_raw[1] = 1'b1;
    for (int k = 1; k <= 25; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL bounce_model: got %b expected %b",
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (in_rise[1]) rises++;
      if (lat == 0 && in_db[1]) lat = k;
    end
    checks++;
    if (lat < 11 || lat > 14 || rises != 1) begin
      errors++;
      $display("FAIL bounce_settle: got lat %0d rises %0d expected 11..14 and 1", lat, rises);
    end
  endtask

  task automatic test_simultaneous();
    logic [2:0] seen;
    seen = '0;
    in_raw[4:2] = 3'b111;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL simul_model: got %b expected %b",
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (seen == '0 && in_rise[4:2] != '0) seen = in_rise[4:2];
    end
    checks++;
    if (seen !== 3'b111) begin
      errors++;
      $display("FAIL simul_rise: got %b expected 111", seen);
    end
    seen = '0;
    in_raw[4:2] = 3'b000;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL simul_model: got %b expected %b",
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (seen == '0 && in_fall[4:2] != '0) seen = in_fall[4:2];
    end
    checks++;
    if (seen !== 3'b111) begin
      errors++;
      $display("FAIL simul_fall: got %b expected 111", seen);
    end
  endtask

  task automatic test_reset_midop();
    int lat, rises;
    lat = 0; rises = 0;
    in_raw = '0;
    repeat (25) cycle();
    checks++;
    if (in_db !== '0) begin
      errors++;
      $display("FAIL midop_idle: got %b expected 0", in_db);
    end
    in_raw[0] = 1'b1;
    repeat (8) cycle();
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (in_db !== '0 || sample_tick !== 1'b0) begin
      errors++;
      $display("FAIL midop_async: got db %b tick %b expected 0", in_db, sample_tick);
    end
    repeat (3) begin
      cycle();
      checks++;
      if (in_db !== '0) begin
        errors++;
        $display("FAIL midop_in_reset: got %b expected 0", in_db);
      end
    end
    rst_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL midop_model: got %b expected %b",
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (in_rise[0]) rises++;
      if (lat == 0 && in_db[0]) lat = k;
    end
    checks++;
    if (lat < 11 || lat > 14 || rises != 1 || in_db[4:1] !== 4'b0000) begin
      errors++;
      $display("FAIL midop_requal: got lat %0d rises %0d db %b expected 11..14 1 0001",
               lat, rises, in_db);
    end
  endtask

  task automatic test_long_press();
    int tk, longs, tk_at, waited;
    tk = 0; longs = 0; tk_at = -1; waited = 0;
    in_raw = '0;
    repeat (25) cycle();
    in_raw[0] = 1'b1;
    while (!in_rise[0] && waited < 20) begin
      cycle();
      waited++;
    end
    checks++;
    if (!in_rise[0]) begin
      errors++;
      $display("FAIL long_rise_timeout: got no rise expected rise within 20");
    end
    for (int k = 1; k <= 60; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL long_model: got %b expected %b",
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (in_long[0]) begin longs++; tk_at = tk; end
      if (sample_tick) tk++;
    end
    checks++;
    if (longs != EXP_LONG) begin
      errors++;
      $display("FAIL long_count: got %0d expected %0d", longs, EXP_LONG);
    end
    if (EXP_LONG == 1) begin
      checks++;
      if (tk_at != LT) begin
        errors++;
        $display("FAIL long_tick: got tick %0d expected %0d", tk_at, LT);
      end
    end
    in_raw[0] = 1'b0;
    repeat (25) cycle();
    in_raw[0] = 1'b1;
    waited = 0;
    while (!in_rise[0] && waited < 20) begin
      cycle();
      waited++;
    end
    in_raw[0] = 1'b0;
    longs = 0;
    for (int k = 1; k <= 40; k++) begin
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL short_model: got %b expected %b",
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      if (in_long[0]) longs++;
    end
    checks++;
    if (longs != 0 || in_db[0] !== 1'b0) begin
      errors++;
      $display("FAIL short_press: got %0d pulses db %b expected 0 0", longs, in_db[0]);
    end
  endtask

  task automatic test_random();
    int left [N];
    for (int i = 0; i < N; i++) left[i] = 0;
    for (int k = 0; k < 800; k++) begin
      for (int i = 0; i < N; i++) begin
        if (left[i] == 0) begin
          in_raw[i] = 1'($urandom_range(0, 1));
          left[i] = $urandom_range(1, 24);
        end else begin
          left[i]--;
        end
      end
      cycle();
      checks++;
      if ({in_db, in_rise, in_fall, in_long, sample_tick} !==
          {m_db, m_rise, m_fall, m_long, m_tick}) begin
        errors++;
        $display("FAIL random_model cyc %0d: got %b expected %b", k,
                 {in_db, in_rise, in_fall, in_long, sample_tick},
                 {m_db, m_rise, m_fall, m_long, m_tick});
      end
      checks++;
      if ((in_rise & in_fall) !== '0) begin
        errors++;
        $display("FAIL random_both_edges: got %b expected 0", in_rise & in_fall);
      end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    in_raw = '0;
    model_reset();
    test_reset();
    test_clean_rise();
    test_bounce();
    test_simultaneous();
    test_reset_midop();
    test_long_press();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
